muldiv_hilo: RTL

Parametrised multi-cycle multiply/divide unit with an integrated HI/LO register pair, used in the execute stage of the MIPS pipeline. It adds multiply-accumulate/subtract, a configurable multiplier latency, a valid/ready request handshake, and cancellation of in-flight operations. It owns all HI/LO state and exposes HI/LO as read ports for MFHI/MFLO.

---
 rtl/muldiv_hilo.sv | 86 ++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide/MAC unit owning the HI/LO register pair
module muldiv_hilo #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, d_mag, rem, quo, rem_nx, quo_nx, a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0] trial, diff;
  logic [2*WIDTH-1:0] prod, mul_res, div_res, res;
  logic accept, is_mul, is_div, last, sgn, ge;
  assign req_ready_o = (state == IDLE) & ~cancel_i;
  assign busy_o = state != IDLE;
  assign accept = req_valid_i & req_ready_o;
  assign is_mul = ~op_i[3] & (op_i[2:1] != 2'b01);
  assign is_div = op_i[3:1] == 3'b001;
  assign last = state == MUL ? cnt == CW'(MUL_LAT - 1) : state == DIV ? cnt == CW'(WIDTH) : 1'b0;
  assign done_o = last & ~cancel_i;
  assign sgn = ~op_q[0];
  assign a_mag = (~op_i[0] & a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (~op_i[0] & b_i[WIDTH-1]) ? -b_i : b_i;
  // one restoring step: shift in the next dividend bit, subtract if it fits
  assign trial = {rem, quo[WIDTH-1]};
  assign diff = trial - {1'b0, d_mag};
  assign ge = trial >= {1'b0, d_mag};
  assign rem_nx = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], ge};
  assign q_fix = (sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo : quo;
  assign r_fix = (sgn & a_q[WIDTH-1]) ? -rem : rem;
  assign div_res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
  assign prod = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
  assign mul_res = ~op_q[2] ? prod : op_q[1] ? {hi_o, lo_o} - prod : {hi_o, lo_o} + prod;
  assign res = state == DIV ? div_res : mul_res;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept & is_mul ? MUL : accept & is_div ? DIV : IDLE)
             : (cancel_i | last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      d_mag <= '0;
      rem   <= '0;
      quo   <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == IDLE || state_nx == IDLE) ? '0 : cnt + 1'b1;
      if (accept) begin
        op_q  <= op_i;
        a_q   <= a_i;
        b_q   <= b_i;
        d_mag <= b_mag;
        quo   <= a_mag;
        rem   <= '0;
      end else if (state == DIV && cnt < CW'(WIDTH)) begin
        rem <= rem_nx;
        quo <= quo_nx;
      end
      if (accept && op_i == 4'd8) hi_o <= a_i;
      if (accept && op_i == 4'd9) lo_o <= a_i;
      if (done_o) {hi_o, lo_o} <= res;
    end
  end
endmodule
